// File: rtl/fsm_general_lectura_if.sv
// Multiplexed address/data bus between the read sequencer and the RTC chip.
// The master drives the address and strobes; the slave (RTC) returns read data on ad_in.
interface fsm_general_lectura_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/fsm_general_lectura.sv
// RTC read sequencer: sweeps six time registers over the multiplexed bus and publishes
// them as one atomically updated BCD snapshot, yielding the bus at register boundaries.
module fsm_general_lectura #(
    parameter int unsigned T_STB  = 4,
    parameter int unsigned T_GAP  = 2,
    parameter int unsigned PERIOD = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic                         i_rd_req,
    input  logic                         i_bus_busy,
    fsm_general_lectura_if.master        io_bus,
    output logic [7:0]                   o_seg,
    output logic [7:0]                   o_min,
    output logic [7:0]                   o_hora,
    output logic [7:0]                   o_dia,
    output logic [7:0]                   o_mes,
    output logic [7:0]                   o_anio,
    output logic                         o_busy,
    output logic                         o_band_fin_lect
);
    localparam logic [15:0] StbLast = 16'(T_STB - 1);
    localparam logic [15:0] GapLast = 16'(T_GAP - 1);
    localparam logic [31:0] PerLast = 32'(PERIOD - 1);
    localparam logic [2:0]  IdxLast = 3'd5;

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrGap, StRead, StReadGap, StSuspend, StDone
    } state_e;

    state_e          r_state, w_state_d;
    logic [15:0]     r_cnt, w_cnt_d;
    logic [2:0]      r_idx, w_idx_d;
    logic            r_pending, w_pending_d;
    logic [31:0]     r_per;
    logic            w_per_hit;
    logic [5:0][7:0] r_shadow;
    logic [5:0][7:0] r_snap;
    logic [7:0]      r_ad_out;
    logic            r_ad_oe, r_cs_n, r_rd_n, r_wr_n, r_a_d;
    logic            r_busy, r_band;

    assign w_per_hit = i_en && (r_per == PerLast);

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt + 16'd1;
        w_idx_d     = r_idx;
        w_pending_d = r_pending || i_rd_req || w_per_hit;
        unique case (r_state)
            StIdle: begin
                if (w_pending_d && !i_bus_busy) begin
                    w_state_d   = StAddr;
                    w_idx_d     = 3'd0;
                    w_pending_d = 1'b0;
                end
            end
            StAddr:    if (r_cnt == StbLast) w_state_d = StAddrGap;
            StAddrGap: if (r_cnt == GapLast) w_state_d = StRead;
            StRead:    if (r_cnt == StbLast) w_state_d = StReadGap;
            StReadGap: begin
                // bus_busy is only honoured here, at the register boundary
                if (r_cnt == GapLast) begin
                    if (r_idx == IdxLast) begin
                        w_state_d = StDone;
                    end else begin
                        w_idx_d   = r_idx + 3'd1;
                        w_state_d = i_bus_busy ? StSuspend : StAddr;
                    end
                end
            end
            StSuspend: if (!i_bus_busy) w_state_d = StAddr;
            StDone: begin
                w_state_d = StIdle;
                w_idx_d   = 3'd0;
            end
            default:   w_state_d = StIdle;
        endcase
        if (w_state_d != r_state) w_cnt_d = 16'd0;
        if (!i_en) begin
            w_state_d   = StIdle;
            w_cnt_d     = 16'd0;
            w_idx_d     = 3'd0;
            w_pending_d = 1'b0;
        end
    end

    // Bus levels are registered from the next state so they line up with r_state glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= 16'd0;
            r_idx     <= 3'd0;
            r_pending <= 1'b0;
            r_per     <= 32'd0;
            r_shadow  <= '0;
            r_snap    <= '0;
            r_ad_out  <= 8'h00;
            r_ad_oe   <= 1'b0;
            r_cs_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_a_d     <= 1'b0;
            r_busy    <= 1'b0;
            r_band    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_idx     <= w_idx_d;
            r_pending <= w_pending_d;
            r_per     <= (!i_en || w_per_hit) ? 32'd0 : r_per + 32'd1;
            r_cs_n    <= !((w_state_d == StAddr) || (w_state_d == StRead));
            r_wr_n    <= (w_state_d != StAddr);
            r_rd_n    <= (w_state_d != StRead);
            r_a_d     <= (w_state_d == StRead);
            r_ad_oe   <= (w_state_d == StAddr);
            r_ad_out  <= (w_state_d == StAddr) ? (8'h21 + {5'd0, w_idx_d}) : 8'h00;
            if (!i_en) begin
                r_shadow <= '0;
            end else if ((r_state == StRead) && (r_cnt == StbLast)) begin
                r_shadow[r_idx] <= io_bus.ad_in;
            end
            if (w_state_d == StDone) r_snap <= r_shadow;
            r_busy    <= (w_state_d != StIdle);
            r_band    <= (w_state_d == StDone);
        end
    end

    assign io_bus.ad_out   = r_ad_out;
    assign io_bus.ad_oe    = r_ad_oe;
    assign io_bus.cs_n     = r_cs_n;
    assign io_bus.rd_n     = r_rd_n;
    assign io_bus.wr_n     = r_wr_n;
    assign io_bus.a_d      = r_a_d;
    assign o_seg           = r_snap[0];
    assign o_min           = r_snap[1];
    assign o_hora          = r_snap[2];
    assign o_dia           = r_snap[3];
    assign o_mes           = r_snap[4];
    assign o_anio          = r_snap[5];
    assign o_busy          = r_busy;
    assign o_band_fin_lect = r_band;
endmodule

// File: tb/tb_fsm_general_lectura.sv
// Bench for fsm_general_lectura: RTC bus model, bus protocol monitor, vector table,
// randomized sweeps against a latency/snapshot model, and abort/reset/request corner cases.
module tb_fsm_general_lectura;
    localparam int T_STB = 4;
    localparam int T_GAP = 2;

    logic clk = 1'b0;
    logic rst, rst2, en, rd_req, bus_busy;
    always #5 clk = ~clk;

    fsm_general_lectura_if bus_if ();
    fsm_general_lectura_if bus_if2 ();

    logic [7:0] seg, mnt, hora, dia, mes, anio;
    logic       busy, band;
    logic [7:0] seg2, mnt2, hora2, dia2, mes2, anio2;
    logic       busy2, band2;
    wire [47:0] snap = {anio, mes, dia, hora, mnt, seg};

    fsm_general_lectura dut (
        .clk(clk), .rst(rst), .i_en(en), .i_rd_req(rd_req), .i_bus_busy(bus_busy),
        .io_bus(bus_if.master), .o_seg(seg), .o_min(mnt), .o_hora(hora), .o_dia(dia),
        .o_mes(mes), .o_anio(anio), .o_busy(busy), .o_band_fin_lect(band)
    );

    fsm_general_lectura #(.PERIOD(100)) dut_per (
        .clk(clk), .rst(rst2), .i_en(1'b1), .i_rd_req(1'b0), .i_bus_busy(1'b0),
        .io_bus(bus_if2.master), .o_seg(seg2), .o_min(mnt2), .o_hora(hora2), .o_dia(dia2),
        .o_mes(mes2), .o_anio(anio2), .o_busy(busy2), .o_band_fin_lect(band2)
    );

    // RTC model: latches the address on write strobes, returns the register on reads
    logic [7:0] mem [6];
    logic [7:0] rtc_lat = 8'h00;
    always @(posedge clk) if (!bus_if.cs_n && !bus_if.wr_n) rtc_lat <= bus_if.ad_out;
    always_comb begin
        bus_if.ad_in = 8'hEE;
        if (rtc_lat >= 8'h21 && rtc_lat <= 8'h26) bus_if.ad_in = mem[3'(rtc_lat - 8'h21)];
    end
    assign bus_if2.ad_in = 8'h00;

    // Protocol monitor
    int   cyc = 0, band_cnt = 0, strobes = 0;
    int   stb_err = 0, gap_err = 0, prot_err = 0, torn_err = 0;
    int   low_cnt = 0, hi_cnt = 100;
    logic prev_cs = 1'b1;
    logic chk_en = 1'b1;
    logic [47:0] prev_snap = '0;
    logic [7:0] addr_q[$];
    int   band2_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (band2) band2_q.push_back(cyc);
        if (rst) begin
            prev_cs   <= 1'b1;
            low_cnt   <= 0;
            hi_cnt    <= 100;
            prev_snap <= snap;
        end else begin
            if (band) band_cnt <= band_cnt + 1;
            if (snap !== prev_snap && !band) torn_err <= torn_err + 1;
            prev_snap <= snap;
            if (!bus_if.cs_n) begin
                if (prev_cs) begin
                    strobes <= strobes + 1;
                    if (chk_en && hi_cnt < T_GAP) gap_err <= gap_err + 1;
                    if (!bus_if.wr_n) addr_q.push_back(bus_if.ad_out);
                    low_cnt <= 1;
                end else begin
                    low_cnt <= low_cnt + 1;
                end
                if (bus_if.wr_n == bus_if.rd_n) prot_err <= prot_err + 1;
                if (!bus_if.wr_n && (!bus_if.ad_oe || bus_if.a_d)) prot_err <= prot_err + 1;
                if (!bus_if.rd_n && (bus_if.ad_oe || !bus_if.a_d)) prot_err <= prot_err + 1;
            end else begin
                if (!prev_cs) begin
                    if (chk_en && low_cnt != T_STB) stb_err <= stb_err + 1;
                    hi_cnt <= 1;
                end else begin
                    hi_cnt <= hi_cnt + 1;
                end
                if (!bus_if.rd_n || !bus_if.wr_n || bus_if.ad_oe) prot_err <= prot_err + 1;
            end
            prev_cs <= bus_if.cs_n;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_mem(input logic [47:0] vals);
        for (int i = 0; i < 6; i++) mem[i] = vals[8*i +: 8];
    endtask

    // One requested sweep; bus_busy is high for cycles [ton, toff) counted from the request
    task automatic run_sweep(input logic [47:0] vals, input int ton, input int toff,
                             output int lat);
        set_mem(vals);
        addr_q.delete();
        lat = -1;
        @(posedge clk);
        #1;
        for (int t = 0; t < 400; t++) begin
            rd_req   = (t == 0);
            bus_busy = (t >= ton && t < toff);
            @(negedge clk);
            if (band) begin
                lat = t;
                break;
            end
            @(posedge clk);
            #1;
        end
        rd_req   = 1'b0;
        bus_busy = 1'b0;
    endtask

    task automatic check_addrs(input string name, input int n_sweeps);
        logic [47:0] a;
        int          bad = 0;
        check({name, "_naddr"}, addr_q.size(), 6 * n_sweeps);
        for (int s = 0; s < n_sweeps; s++) begin
            a = '0;
            for (int i = 0; i < 6; i++)
                if (6 * s + i < addr_q.size()) a[8*i +: 8] = addr_q[6 * s + i];
            if (a !== 48'h26_25_24_23_22_21) bad++;
        end
        check({name, "_addr_seq_bad"}, bad, 0);
    endtask

    // Reference: suspension only at register boundaries (12k cycles in, k=1..5)
    function automatic int model_lat(input int ton, input int toff);
        int per_reg = 2 * (T_STB + T_GAP);
        for (int k = 1; k <= 5; k++) begin
            if (per_reg * k >= ton && per_reg * k < toff) return 6 * per_reg + 1 + toff
                - per_reg * k;
        end
        return 6 * per_reg + 1;
    endfunction

    typedef struct {
        logic [47:0] vals;
        int          ton;
        int          toff;
        int          lat;
    } vec_t;

    vec_t        vecs[5];
    int          lat, b0, s0, bad;
    logic [47:0] prev, rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{48'h16_05_09_12_30_45, 0, 0, 73};
        vecs[1] = '{48'h99_12_31_23_59_58, 32, 52, 89};
        vecs[2] = '{48'h20_01_15_08_07_06, 5, 13, 74};
        vecs[3] = '{48'h21_02_28_17_44_33, 5, 12, 73};
        vecs[4] = '{48'h22_11_30_00_00_01, 72, 80, 73};

        rst = 1'b1; rst2 = 1'b1; en = 1'b0; rd_req = 1'b0; bus_busy = 1'b0;
        set_mem('0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst2 = 1'b0; en = 1'b1;
        @(negedge clk);
        check("rst_cs_n", bus_if.cs_n, 1);
        check("rst_rd_n", bus_if.rd_n, 1);
        check("rst_wr_n", bus_if.wr_n, 1);
        check("rst_a_d", bus_if.a_d, 0);
        check("rst_ad_oe", bus_if.ad_oe, 0);
        check("rst_ad_out", bus_if.ad_out, 8'h00);
        check("rst_snap", snap, 0);
        check("rst_busy", busy, 0);
        check("rst_band", band, 0);

        for (int v = 0; v < 5; v++) begin
            run_sweep(vecs[v].vals, vecs[v].ton, vecs[v].toff, lat);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d_snap", v), snap, vecs[v].vals);
            check_addrs($sformatf("vec%0d", v), 1);
            repeat (2) @(posedge clk);
        end

        for (int r = 0; r < 8; r++) begin
            int ton, toff;
            rv = 48'({$urandom(), $urandom()});
            ton = $urandom_range(1, 70);
            toff = ton + $urandom_range(0, 30);
            if ($urandom_range(0, 2) == 0) begin
                ton = 0;
                toff = 0;
            end
            repeat ($urandom_range(1, 5)) @(posedge clk);
            run_sweep(rv, ton, toff, lat);
            check($sformatf("rnd%0d_latency", r), lat, model_lat(ton, toff));
            check($sformatf("rnd%0d_snap", r), snap, rv);
            check_addrs($sformatf("rnd%0d", r), 1);
        end

        // En dropped during index 4 READ
        repeat (2) @(posedge clk);
        prev = snap;
        set_mem(48'h33_44_55_66_77_88);
        chk_en = 1'b0;
        @(posedge clk); #1 rd_req = 1'b1;
        @(posedge clk); #1 rd_req = 1'b0;
        repeat (54) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("en_pre_rd_n", bus_if.rd_n, 0);
        check("en_pre_busy", busy, 1);
        b0 = band_cnt;
        @(negedge clk);
        check("en_cs_n", bus_if.cs_n, 1);
        check("en_busy", busy, 0);
        check("en_ad_oe", bus_if.ad_oe, 0);
        check("en_snap_held", snap, prev);
        repeat (10) @(posedge clk);
        #1 check("en_no_band", band_cnt, b0);
        en = 1'b1;
        chk_en = 1'b1;
        run_sweep(48'h10_04_03_02_01_00, 0, 0, lat);
        check("en_restart_latency", lat, 73);
        check("en_restart_snap", snap, 48'h10_04_03_02_01_00);
        check_addrs("en_restart", 1);

        // Asynchronous reset in the middle of index 2 READ
        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        b0 = band_cnt;
        @(posedge clk); #1 rd_req = 1'b1;
        @(posedge clk); #1 rd_req = 1'b0;
        repeat (32) @(posedge clk);
        #2 check("arst_pre_rd_n", bus_if.rd_n, 0);
        #1 rst = 1'b1;
        #1;
        check("arst_cs_n", bus_if.cs_n, 1);
        check("arst_rd_n", bus_if.rd_n, 1);
        check("arst_busy", busy, 0);
        check("arst_snap", snap, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1 check("arst_no_band", band_cnt, b0);
        check("arst_idle", busy, 0);
        chk_en = 1'b1;

        // Three requests during a sweep collapse into one extra sweep
        set_mem(48'h24_06_18_21_15_09);
        addr_q.delete();
        b0 = band_cnt;
        @(posedge clk); #1;
        for (int t = 0; t < 300; t++) begin
            rd_req = (t == 0 || t == 10 || t == 20 || t == 30);
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;
        check("multi_req_bands", band_cnt - b0, 2);
        check_addrs("multi_req", 2);
        check("multi_req_snap", snap, 48'h24_06_18_21_15_09);

        // Bus owned by the write controller at request time
        set_mem(48'h25_07_19_22_16_10);
        s0 = strobes;
        @(posedge clk); #1 bus_busy = 1'b1; rd_req = 1'b1;
        @(posedge clk); #1 rd_req = 1'b0;
        repeat (30) @(posedge clk);
        #1 check("hold_no_strobes", strobes, s0);
        check("hold_not_busy", busy, 0);
        lat = -1;
        for (int t = 0; t < 200; t++) begin
            bus_busy = 1'b0;
            @(negedge clk);
            if (band) begin
                lat = t;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("hold_latency", lat, 73);
        check("hold_snap", snap, 48'h25_07_19_22_16_10);

        // Periodic instance: fixed spacing between publications
        bad = 0;
        for (int i = 1; i < band2_q.size(); i++)
            if (band2_q[i] - band2_q[i-1] != 100) bad++;
        check("period_enough_pulses", band2_q.size() >= 3, 1);
        check("period_bad_spacing", bad, 0);

        check("mon_strobe_width_err", stb_err, 0);
        check("mon_gap_err", gap_err, 0);
        check("mon_protocol_err", prot_err, 0);
        check("mon_torn_update_err", torn_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fsm_general_lectura.md
# fsm_general_lectura

Read sequencer for the RTC parallel bus: the reading counterpart of the write/programming controller. When a sweep is requested (periodic tick or explicit request), it reads six time registers from the RTC chip over the multiplexed address/data bus, using address-write and data-read strobes. It presents the results as a coherent, atomically updated BCD snapshot to the display/formatting logic. It yields the bus to the write controller whenever that controller is active.

## Interface
- T_STB, 4: strobe (CS/WR or CS/RD low) width in clocks, ≥1
- T_GAP, 2: all-strobes-high gap after each strobe, ≥1
- PERIOD, 1_000_000: clocks between automatic sweep requests, ≥2
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- En  in  1  block enable; low aborts immediately
- rd_req  in  1  one-cycle request for an immediate sweep
- bus_busy  in  1  write controller owns the bus (its In OR en_progra)
- ad_in  in  8  data bus from RTC
- ad_out  out  8  address driven onto the bus
- ad_oe  out  1  tri-state enable for ad_out
- cs_n, rd_n, wr_n  out  1 each  active-low chip select, read, write strobes
- a_d  out  1  0 = address cycle, 1 = data cycle
- seg, min, hora, dia, mes, anio  out  8 each  BCD snapshot
- busy  out  1  sweep in progress (not IDLE)
- band_fin_lect  out  1  one-cycle pulse when a new snapshot is published

## Operation
- Register table, index 0..5: 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio.
- States: IDLE, ADDR, ADDR_GAP, READ, READ_GAP, SUSPEND, DONE.
- pending flag: set by rd_req, or by period counter reaching PERIOD-1 (it then wraps to 0). Cleared on entering ADDR for index 0. The period counter runs only while En=1 and is cleared while En=0.
- IDLE → ADDR(index 0) when pending=1, En=1, bus_busy=0.
- ADDR, T_STB cycles: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=table[index].
- ADDR_GAP, T_GAP cycles: strobes high, ad_oe=0.
- READ, T_STB cycles: cs_n=0, rd_n=0, a_d=1, ad_oe=0. ad_in is sampled into shadow[index] on the last READ cycle.
- READ_GAP, T_GAP cycles: strobes high. Then:
  - index=5 → DONE.
  - bus_busy=1 → SUSPEND.
  - otherwise index+1 → ADDR.
- SUSPEND: strobes high, ad_oe=0. Returns to ADDR at the saved index when bus_busy=0.
- DONE, 1 cycle: all six shadows are copied to the outputs simultaneously, band_fin_lect=1, index=0, then IDLE.
- bus_busy rising mid-register never interrupts the current ADDR…READ_GAP access. It only takes effect at the register boundary.
- En=0 in any state: next cycle is IDLE, strobes high, ad_oe=0, index=0, shadows discarded, pending cleared, outputs hold their last snapshot.
- rd_req while busy=1 sets pending, so exactly one further sweep follows DONE. Multiple such requests collapse into one.
- Outputs are registered and decoded so each state's bus levels hold for exactly that state's cycle count. No strobe glitches occur between states.

## Timing
- Reset values: cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_out=0x00, all snapshot outputs 0x00, busy=0, band_fin_lect=0, index=0, pending=0, period counter 0.
- Per register: 2·(T_STB+T_GAP) clocks, 12 at defaults.
- Sweep latency: first ADDR cycle is the clock after the request is accepted. band_fin_lect is asserted 6·2·(T_STB+T_GAP)+1 clocks later (73 at defaults) when no suspension occurs.
- cs_n is never low during consecutive cycles of different accesses; the minimum high time between strobes is T_GAP.
- Snapshot outputs change only in the DONE cycle, so there is never a partial/torn update.

## Test plan
- Default parameters, RTC model returning 0x45,0x30,0x12,0x09,0x05,0x16; pulse rd_req → ad_out sequence 0x21..0x26 with 4-cycle strobes, band_fin_lect pulse 73 clocks later, outputs equal those values, outputs 0x00 until that cycle.
- PERIOD=100, no rd_req → sweeps start every 100 clocks; band_fin_lect pulses at a fixed 100-clock spacing; no overlap.
- bus_busy raised during index 2 READ → index 2 completes, SUSPEND with all strobes high; drop bus_busy 20 clocks later → resumes at 0x24, final snapshot correct, latency 73+SUSPEND time.
- En dropped during index 4 → next cycle strobes high, busy=0, outputs keep previous snapshot; re-enable plus rd_req → full sweep restarts at 0x21.
- Asynchronous reset asserted mid-READ (not clock-aligned) → all outputs go to reset values immediately; no band_fin_lect pulse.
- rd_req pulsed three times during a sweep → exactly one additional sweep; bus_busy held high at request time → no strobes until it falls.
